// File: rtl/audio_voice_mixer_if.sv
// Voice fetch handshake and mixed-sample output shared by the mixer and its voices/PWM stage.
interface audio_voice_mixer_if #(
  parameter int NUM_VOICES = 4,
  parameter int AUD_BITS   = 12
);
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic                       fetch_req;
  logic [IDX_W-1:0]           fetch_idx;
  logic                       fetch_ack;
  logic signed [AUD_BITS-1:0] fetch_data;
  logic signed [AUD_BITS-1:0] mix_audio;
  logic                       mix_valid;

  modport master (
    output fetch_req, fetch_idx, mix_audio, mix_valid,
    input  fetch_ack, fetch_data
  );

  modport slave (
    input  fetch_req, fetch_idx, mix_audio, mix_valid,
    output fetch_ack, fetch_data
  );
endinterface

// File: rtl/audio_voice_mixer.sv
// Polls enabled voices once per sample strobe, scales each by its volume and presents one
// saturated mixed sample (held until the next round completes).
module audio_voice_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int AUD_BITS   = 12,
  parameter int VOL_BITS   = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           sample_req,
  input  logic [NUM_VOICES-1:0]          voice_en,
  input  logic [NUM_VOICES*VOL_BITS-1:0] voice_vol,
  input  logic                           status_clr,
  output logic                           busy,
  output logic [NUM_VOICES-1:0]          timeout_flags,
  output logic                           overrun,
  audio_voice_mixer_if.master            bus
);
  localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int PROD_W = AUD_BITS + VOL_BITS + 1;
  localparam int ACC_W  = PROD_W + $clog2(NUM_VOICES);
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-AUD_BITS+1){1'b0}}, {(AUD_BITS-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-AUD_BITS+1){1'b1}}, {(AUD_BITS-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_WAIT, S_ACC, S_NEXT, S_DONE
  } state_t;

  state_t                     state;
  state_t                     state_nxt;
  logic [IDX_W-1:0]           idx;
  logic [CNT_W-1:0]           cnt;
  logic signed [AUD_BITS-1:0] sample;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    acc_shift;
  logic signed [PROD_W-1:0]   prod;
  logic signed [AUD_BITS-1:0] sat_val;
  logic [VOL_BITS-1:0]        vol_sel;
  logic                       tmo_hit;
  logic                       last_voice;

  // An ack on the deadline cycle takes priority over the timeout.
  assign tmo_hit    = (state == S_WAIT) && !bus.fetch_ack && (cnt == CNT_W'(TIMEOUT - 1));
  assign last_voice = (idx == IDX_W'(NUM_VOICES - 1));
  assign vol_sel    = voice_vol[idx*VOL_BITS +: VOL_BITS];
  assign prod       = PROD_W'(sample) * PROD_W'($signed({1'b0, vol_sel}));
  assign acc_shift  = acc >>> VOL_BITS;
  assign bus.fetch_idx = idx;

  always_comb begin
    sat_val = acc_shift[AUD_BITS-1:0];
    if (acc_shift > SAT_MAX) begin
      sat_val = {1'b0, {(AUD_BITS-1){1'b1}}};
    end else if (acc_shift < SAT_MIN) begin
      sat_val = {1'b1, {(AUD_BITS-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (sample_req) state_nxt = S_SCAN;
      S_SCAN:  state_nxt = voice_en[idx] ? S_WAIT : S_NEXT;
      S_WAIT:  if (bus.fetch_ack || tmo_hit) state_nxt = S_ACC;
      S_ACC:   state_nxt = S_NEXT;
      S_NEXT:  state_nxt = last_voice ? S_DONE : S_SCAN;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.fetch_req = (state == S_WAIT);
    bus.mix_valid = (state == S_DONE);
    busy          = (state != S_IDLE);
  end

  // mix_audio is loaded on the NEXT->DONE step so it is already valid during the pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx           <= '0;
      cnt           <= '0;
      sample        <= '0;
      acc           <= '0;
      bus.mix_audio <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sample_req) begin
            acc <= '0;
            idx <= '0;
          end
        end
        S_SCAN: cnt <= '0;
        S_WAIT: begin
          if (bus.fetch_ack) begin
            sample <= bus.fetch_data;
          end else if (tmo_hit) begin
            sample <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_ACC:  acc <= acc + ACC_W'(prod);
        S_NEXT: begin
          if (last_voice) begin
            bus.mix_audio <= sat_val;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Later assignments win, so a new flag event beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_flags <= '0;
      overrun       <= 1'b0;
    end else begin
      if (status_clr) begin
        timeout_flags <= '0;
        overrun       <= 1'b0;
      end
      if (tmo_hit) begin
        timeout_flags[idx] <= 1'b1;
      end
      if (sample_req && (state != S_IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end
endmodule
